pci_device_param: RTL and testbench
===================================

Name: pci_device_param

Overview:
- Parametrised PCI-style bus device; next generation of the team's single-word bus device.
- Contains an initiator engine (burst read/write driven from a local host interface) and a target engine (local word memory with byte-enable writes, programmable wait states).
- Uses real PCI memory-read/memory-write command codes and a master-abort timeout.
- Sits on the shared bus with the arbiter and other devices; all bus control signals are active-low.

Parameters:
DEPTH, 16, target memory words (power of 2)
ADDR_W, 4, log2(DEPTH), word-offset width
DEV_ID_W, 2, device-ID width
WAIT_STATES, 0, target cycles inserted before each TRDY assertion (0..7)
MAX_BURST, 8, maximum initiator burst length in words
ABORT_TIMEOUT, 4, cycles after address phase without DEVSEL before master abort

Ports:
CLK  input  1  bus clock, all logic on posedge
RST  input  1  asynchronous, active-low reset
DeviceAddress  input  DEV_ID_W  this device's ID
start  input  1  pulse: launch initiator transaction (ignored while busy)
xfer_write  input  1  1=memory write, 0=memory read
xfer_target  input  DEV_ID_W  target device ID
xfer_offset  input  ADDR_W  starting word offset
xfer_len  input  4  burst words, 1..MAX_BURST (0 treated as 1)
wdata_in  input  32  write data word
byte_en  input  4  active-high byte enables for writes
wdata_ack  output  1  pulse: current wdata_in consumed
rdata_out  output  32  read data word
rdata_valid  output  1  pulse: rdata_out valid
busy  output  1  initiator transaction in progress
done  output  1  pulse: transaction finished
err  output  1  with done: master abort occurred
REQ  output  1  bus request, active-low
GNT  input  1  bus grant, active-low
FRAME, IRDY  inout  1  driven only while initiator owns bus
TRDY, DEVSEL  inout  1  driven only while target selected
AD  inout  32  address/data
CBE  inout  4  command / active-low byte enables

Behaviour:
- Reset (async, RST=0): REQ=1; busy, done, err, wdata_ack, rdata_valid=0; all inouts Z immediately; both FSMs to IDLE; burst/wait counters 0. Memory is not reset.
- Address format: AD[ADDR_W+1:2]=word offset; AD[DEV_ID_W+15:16]=device ID; all other bits 0.
- Commands: CBE=4'b0110 read, 4'b0111 write. Other codes are ignored by the target.
- Bus idle means FRAME=1 and IRDY=1, both sampled.
- Initiator FSM (IDLE, REQ, ADDR, DATA, TURN):
  - IDLE: on start, latch inputs; busy=1; REQ=0; go to REQ.
  - REQ: when GNT=0 and bus idle, go to ADDR.
  - ADDR (1 cycle): FRAME=0, AD=address, CBE=cmd; REQ=1.
  - DATA: IRDY=0.
    - Write: AD=wdata_in, CBE=~byte_en.
    - Read: AD released, CBE=4'b0000.
  - A word transfers on each edge where IRDY=0 and TRDY=0 are sampled.
    - Write: wdata_ack pulses on that edge.
    - Read: rdata_out=AD, rdata_valid=1 on the following cycle.
  - FRAME=1 is driven during the last data phase (remaining=1).
  - After the last transfer, go to TURN: FRAME/IRDY driven 1 for one cycle, then Z. done=1 for 1 cycle; busy=0.
  - Master abort: no DEVSEL=0 within ABORT_TIMEOUT cycles after ADDR. Deassert FRAME, then IRDY; go to TURN; done=1, err=1.
- Target FSM (IDLE, DECODE, WAIT, XFER, TURN):
  - IDLE: a FRAME 1->0 transition with AD device ID = DeviceAddress and a valid command latches the offset and direction.
  - A transaction this device initiates is never claimed by its own target (initiator gets master abort).
  - Next cycle: DEVSEL=0, TRDY=1.
  - WAIT: counts WAIT_STATES cycles, then TRDY=0 (XFER). With WAIT_STATES=0, TRDY=0 in the same cycle as DEVSEL.
  - XFER, transfer on IRDY=0 & TRDY=0:
    - Write: memory[offset] byte lane i is written when CBE[i]=0.
    - Read: AD=memory[offset] is driven while TRDY=0 (read target drives AD from the DEVSEL cycle onward).
  - Offset increments mod DEPTH (wrap to 0).
  - With WAIT_STATES>0, TRDY returns to 1 and WAIT reloads after every word.
  - A transfer with FRAME=1 sampled is the last: go to TURN, drive DEVSEL/TRDY=1 for one cycle, then Z.
- A simultaneous start and incoming target access are handled independently; the two FSMs share only the memory-free bus pins.
- Reset mid-transaction: bus released immediately; no done pulse.

Test Plan:
- Write burst: RST pulse; dev A (ID 1) start write, target 2, offset 3, len 4, data 0x11111111..0x44444444, byte_en=4'hF. -> dev B memory[3..6] hold the data; 4 wdata_ack pulses; done=1, err=0.
- Read burst with wrap: dev B memory preloaded with memory[15]=0xAAAA0000, [0]=0xBBBB0001; read offset 15, len 2. -> rdata_out 0xAAAA0000 then 0xBBBB0001.
- Byte enables: write 0xDEADBEEF with byte_en=4'b0101 to a word holding 0. -> stored word is 0x00AD00EF.
- Wait states: dev B with WAIT_STATES=2, write len 3. -> TRDY=0 for exactly 1 cycle of every 3; total data phase 9 cycles.
- Master abort: read to unused ID 3. -> no DEVSEL; done and err assert ABORT_TIMEOUT+2 cycles after ADDR; FRAME/IRDY released.
- Mid-burst reset: RST=0 during DATA. -> AD/FRAME/IRDY/DEVSEL/TRDY go Z at once; busy=0, REQ=1.

Source files
------------

// File: rtl/pci_device_param.sv
// PCI-style bus device: burst initiator driven from a local host port, plus a
// target with a byte-enabled word memory and programmable wait states.
module pci_device_param #(
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned ADDR_W        = 4,
    parameter int unsigned DEV_ID_W      = 2,
    parameter int unsigned WAIT_STATES   = 0,
    parameter int unsigned MAX_BURST     = 8,
    parameter int unsigned ABORT_TIMEOUT = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [DEV_ID_W-1:0] DeviceAddress,
    input  logic                start,
    input  logic                xfer_write,
    input  logic [DEV_ID_W-1:0] xfer_target,
    input  logic [ADDR_W-1:0]   xfer_offset,
    input  logic [3:0]          xfer_len,
    input  logic [31:0]         wdata_in,
    input  logic [3:0]          byte_en,
    output logic                wdata_ack,
    output logic [31:0]         rdata_out,
    output logic                rdata_valid,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                REQ,
    input  logic                GNT,
    inout  wire                 FRAME,
    inout  wire                 IRDY,
    inout  wire                 TRDY,
    inout  wire                 DEVSEL,
    inout  wire  [31:0]         AD,
    inout  wire  [3:0]          CBE
);
    localparam int unsigned ABORT_W = $clog2(ABORT_TIMEOUT + 1);
    localparam logic [3:0] CMD_RD = 4'b0110;
    localparam logic [3:0] CMD_WR = 4'b0111;
    localparam logic [2:0] WAIT_RELOAD = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

    typedef enum logic [2:0] {I_IDLE, I_REQ, I_ADDR, I_DATA, I_TURN} ist_t;
    typedef enum logic [2:0] {T_IDLE, T_DECODE, T_WAIT, T_XFER, T_TURN} tst_t;

    ist_t ist, ist_d;
    logic                wr_q, wr_d;
    logic [DEV_ID_W-1:0] tgt_q, tgt_d;
    logic [ADDR_W-1:0]   off_q, off_d;
    logic [3:0]          rem_q, rem_d;
    logic [ABORT_W-1:0]  acnt_q, acnt_d;
    logic                abort_q, abort_d, seen_q, seen_d;
    logic                req_n_d, busy_d, done_d, err_d, wack_d, rvalid_d;
    logic [31:0]         rdata_d;
    logic                frame_oe_q, frame_oe_d, frame_o_q, frame_o_d;
    logic                irdy_oe_q, irdy_oe_d, irdy_o_q, irdy_o_d;
    logic                iad_oe_q, iad_oe_d, cbe_oe_q, cbe_oe_d;
    logic [3:0]          len_eff_c;

    tst_t tst, tst_d;
    logic [ADDR_W-1:0]   toff_q, toff_d;
    logic                twr_q, twr_d;
    logic [2:0]          wcnt_q, wcnt_d;
    logic                frame_q;
    logic                tgt_oe_q, tgt_oe_d, devsel_o_q, devsel_o_d, trdy_o_q, trdy_o_d;
    logic                tad_oe_q, tad_oe_d, mem_we_c;
    logic [31:0]         mem [DEPTH];

    logic [31:0]         addr_c, ad_val_c;
    logic [3:0]          cbe_val_c;

    assign len_eff_c = (xfer_len == 4'd0) ? 4'd1 :
                       ((32'(xfer_len) > MAX_BURST) ? 4'(MAX_BURST) : xfer_len);
    assign addr_c    = (32'(tgt_q) << 16) | (32'(off_q) << 2);

    // Bus pins: address/write data from the initiator, read data from the target
    assign ad_val_c  = iad_oe_q ? ((ist == I_ADDR) ? addr_c : wdata_in) : mem[toff_q];
    assign cbe_val_c = (ist == I_ADDR) ? (wr_q ? CMD_WR : CMD_RD) : (wr_q ? ~byte_en : 4'h0);
    assign AD        = (iad_oe_q || tad_oe_q) ? ad_val_c : 32'bz;
    assign CBE       = cbe_oe_q ? cbe_val_c : 4'bz;
    assign FRAME     = frame_oe_q ? frame_o_q : 1'bz;
    assign IRDY      = irdy_oe_q ? irdy_o_q : 1'bz;
    assign DEVSEL    = tgt_oe_q ? devsel_o_q : 1'bz;
    assign TRDY      = tgt_oe_q ? trdy_o_q : 1'bz;

    // Initiator next state; abort counts sampled DEVSEL=1 edges after ADDR
    always_comb begin
        ist_d    = ist;
        wr_d     = wr_q;
        tgt_d    = tgt_q;
        off_d    = off_q;
        rem_d    = rem_q;
        acnt_d   = acnt_q;
        abort_d  = abort_q;
        seen_d   = seen_q;
        err_d    = 1'b0;
        wack_d   = 1'b0;
        rvalid_d = 1'b0;
        rdata_d  = rdata_out;
        case (ist)
            I_IDLE: if (start) begin
                ist_d   = I_REQ;
                wr_d    = xfer_write;
                tgt_d   = xfer_target;
                off_d   = xfer_offset;
                rem_d   = len_eff_c;
                acnt_d  = '0;
                abort_d = 1'b0;
                seen_d  = 1'b0;
            end
            I_REQ:  if (!GNT && FRAME && IRDY) ist_d = I_ADDR;
            I_ADDR: ist_d = I_DATA;
            I_DATA: begin
                if (!DEVSEL) seen_d = 1'b1;
                if (abort_q) begin
                    ist_d = I_TURN;
                    err_d = 1'b1;
                end else if (!IRDY && !TRDY) begin
                    wack_d   = wr_q;
                    rvalid_d = !wr_q;
                    if (!wr_q) rdata_d = AD;
                    if (rem_q == 4'd1) ist_d = I_TURN;
                    else rem_d = rem_q - 4'd1;
                end else if (DEVSEL && !seen_q) begin
                    acnt_d = acnt_q + ABORT_W'(1);
                    if (acnt_d == ABORT_W'(ABORT_TIMEOUT)) abort_d = 1'b1;
                end
            end
            I_TURN:  ist_d = I_IDLE;
            default: ist_d = I_IDLE;
        endcase
        req_n_d    = (ist_d != I_REQ);
        busy_d     = (ist_d == I_REQ) || (ist_d == I_ADDR) || (ist_d == I_DATA);
        done_d     = (ist_d == I_TURN);
        frame_oe_d = (ist_d == I_ADDR) || (ist_d == I_DATA) || (ist_d == I_TURN);
        frame_o_d  = !((ist_d == I_ADDR) || ((ist_d == I_DATA) && (rem_d != 4'd1) && !abort_d));
        irdy_oe_d  = (ist_d == I_DATA) || (ist_d == I_TURN);
        irdy_o_d   = (ist_d != I_DATA);
        iad_oe_d   = (ist_d == I_ADDR) || ((ist_d == I_DATA) && wr_d);
        cbe_oe_d   = (ist_d == I_ADDR) || (ist_d == I_DATA);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ist         <= I_IDLE;
            wr_q        <= 1'b0;
            tgt_q       <= '0;
            off_q       <= '0;
            rem_q       <= '0;
            acnt_q      <= '0;
            abort_q     <= 1'b0;
            seen_q      <= 1'b0;
            REQ         <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            wdata_ack   <= 1'b0;
            rdata_valid <= 1'b0;
            rdata_out   <= '0;
            frame_oe_q  <= 1'b0;
            frame_o_q   <= 1'b1;
            irdy_oe_q   <= 1'b0;
            irdy_o_q    <= 1'b1;
            iad_oe_q    <= 1'b0;
            cbe_oe_q    <= 1'b0;
        end else begin
            ist         <= ist_d;
            wr_q        <= wr_d;
            tgt_q       <= tgt_d;
            off_q       <= off_d;
            rem_q       <= rem_d;
            acnt_q      <= acnt_d;
            abort_q     <= abort_d;
            seen_q      <= seen_d;
            REQ         <= req_n_d;
            busy        <= busy_d;
            done        <= done_d;
            err         <= err_d;
            wdata_ack   <= wack_d;
            rdata_valid <= rvalid_d;
            rdata_out   <= rdata_d;
            frame_oe_q  <= frame_oe_d;
            frame_o_q   <= frame_o_d;
            irdy_oe_q   <= irdy_oe_d;
            irdy_o_q    <= irdy_o_d;
            iad_oe_q    <= iad_oe_d;
            cbe_oe_q    <= cbe_oe_d;
        end
    end

    // Target next state; our own address phase is never claimed
    always_comb begin
        tst_d    = tst;
        toff_d   = toff_q;
        twr_d    = twr_q;
        wcnt_d   = wcnt_q;
        mem_we_c = 1'b0;
        case (tst)
            T_IDLE: if (frame_q && !FRAME && (ist != I_ADDR) &&
                        (AD[DEV_ID_W+15:16] == DeviceAddress) &&
                        ((CBE == CMD_RD) || (CBE == CMD_WR))) begin
                toff_d = AD[ADDR_W+1:2];
                twr_d  = CBE[0];
                wcnt_d = WAIT_RELOAD;
                if (WAIT_STATES == 0) tst_d = T_XFER;
                else tst_d = T_DECODE;
            end
            T_DECODE, T_WAIT: begin
                if (wcnt_q == 3'd0) tst_d = T_XFER;
                else begin
                    wcnt_d = wcnt_q - 3'd1;
                    tst_d  = T_WAIT;
                end
            end
            T_XFER: if (!IRDY) begin
                mem_we_c = twr_q;
                toff_d   = toff_q + ADDR_W'(1);
                wcnt_d   = WAIT_RELOAD;
                if (FRAME) tst_d = T_TURN;
                else if (WAIT_STATES == 0) tst_d = T_XFER;
                else tst_d = T_WAIT;
            end
            T_TURN:  tst_d = T_IDLE;
            default: tst_d = T_IDLE;
        endcase
        tgt_oe_d   = (tst_d != T_IDLE);
        devsel_o_d = (tst_d == T_TURN);
        trdy_o_d   = (tst_d != T_XFER);
        tad_oe_d   = !twr_d && ((tst_d == T_DECODE) || (tst_d == T_WAIT) || (tst_d == T_XFER));
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tst        <= T_IDLE;
            toff_q     <= '0;
            twr_q      <= 1'b0;
            wcnt_q     <= '0;
            frame_q    <= 1'b1;
            tgt_oe_q   <= 1'b0;
            devsel_o_q <= 1'b1;
            trdy_o_q   <= 1'b1;
            tad_oe_q   <= 1'b0;
        end else begin
            tst        <= tst_d;
            toff_q     <= toff_d;
            twr_q      <= twr_d;
            wcnt_q     <= wcnt_d;
            frame_q    <= FRAME;
            tgt_oe_q   <= tgt_oe_d;
            devsel_o_q <= devsel_o_d;
            trdy_o_q   <= trdy_o_d;
            tad_oe_q   <= tad_oe_d;
        end
    end

    // Target memory: byte lanes written where the active-low enable is 0
    always_ff @(posedge CLK) begin
        if (mem_we_c) begin
            for (int i = 0; i < 4; i++) begin
                if (!CBE[i]) mem[toff_q][8*i +: 8] <= AD[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_pci_device_param.sv
// Bench: device A (ID 1) initiates; B (ID 2, no waits) and C (ID 0, 2 waits) are targets.
module tb_pci_device_param;

    typedef struct packed {
        logic            wr;
        logic [1:0]      tgt;
        logic [3:0]      off;
        logic [3:0]      len;
        logic [3:0][31:0] data;
        logic [3:0]      be;
        logic            err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start, xfer_write;
    logic [1:0]  xfer_target;
    logic [3:0]  xfer_offset, xfer_len, byte_en;
    logic [31:0] wdata_in;

    wire frame, irdy, trdy, devsel;
    wire [31:0] ad;
    wire [3:0]  cbe;
    pullup (frame);
    pullup (irdy);
    pullup (trdy);
    pullup (devsel);
    pullup (ad);
    pullup (cbe);

    logic        a_wack, a_rvalid, a_busy, a_done, a_err, a_req;
    logic [31:0] a_rdata;
    logic        b_wack, b_rvalid, b_busy, b_done, b_err, b_req;
    logic [31:0] b_rdata;
    logic        c_wack, c_rvalid, c_busy, c_done, c_err, c_req;
    logic [31:0] c_rdata;
    wire         gnt_a = a_req;

    int nchk = 0, nerr = 0;
    int n_irdy, n_trdy, n_dsel, pat_bad, addr_cyc, done_cyc;
    logic post_frame, post_irdy;
    vec_t vecs [7];

    always #5 clk = ~clk;

    pci_device_param #(.WAIT_STATES(0)) u_a (
        .CLK(clk), .RST(rst_n), .DeviceAddress(2'd1), .start(start), .xfer_write(xfer_write),
        .xfer_target(xfer_target), .xfer_offset(xfer_offset), .xfer_len(xfer_len),
        .wdata_in(wdata_in), .byte_en(byte_en), .wdata_ack(a_wack), .rdata_out(a_rdata),
        .rdata_valid(a_rvalid), .busy(a_busy), .done(a_done), .err(a_err), .REQ(a_req),
        .GNT(gnt_a), .FRAME(frame), .IRDY(irdy), .TRDY(trdy), .DEVSEL(devsel), .AD(ad), .CBE(cbe));

    pci_device_param #(.WAIT_STATES(0)) u_b (
        .CLK(clk), .RST(rst_n), .DeviceAddress(2'd2), .start(1'b0), .xfer_write(1'b0),
        .xfer_target(2'd0), .xfer_offset(4'd0), .xfer_len(4'd0),
        .wdata_in(32'd0), .byte_en(4'd0), .wdata_ack(b_wack), .rdata_out(b_rdata),
        .rdata_valid(b_rvalid), .busy(b_busy), .done(b_done), .err(b_err), .REQ(b_req),
        .GNT(1'b1), .FRAME(frame), .IRDY(irdy), .TRDY(trdy), .DEVSEL(devsel), .AD(ad), .CBE(cbe));

    pci_device_param #(.WAIT_STATES(2)) u_c (
        .CLK(clk), .RST(rst_n), .DeviceAddress(2'd0), .start(1'b0), .xfer_write(1'b0),
        .xfer_target(2'd0), .xfer_offset(4'd0), .xfer_len(4'd0),
        .wdata_in(32'd0), .byte_en(4'd0), .wdata_ack(c_wack), .rdata_out(c_rdata),
        .rdata_valid(c_rvalid), .busy(c_busy), .done(c_done), .err(c_err), .REQ(c_req),
        .GNT(1'b1), .FRAME(frame), .IRDY(irdy), .TRDY(trdy), .DEVSEL(devsel), .AD(ad), .CBE(cbe));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [1:0] tgt, input logic [3:0] off,
                                input logic [3:0] len, input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3,
                                input logic [3:0] be, input logic e);
        vec_t v;
        v.wr = wr; v.tgt = tgt; v.off = off; v.len = len;
        v.data = {d3, d2, d1, d0}; v.be = be; v.err = e;
        return v;
    endfunction

    // One host transaction on device A; data holds write words or expected read words
    task automatic run_txn(input vec_t v, input string tag);
        int nack = 0, nrd = 0;
        bit got_done = 1'b0;
        logic e = 1'b0;
        logic busy_at_done = 1'b1;
        n_irdy = 0; n_trdy = 0; n_dsel = 0; pat_bad = 0; addr_cyc = -1; done_cyc = -1;
        xfer_write = v.wr; xfer_target = v.tgt; xfer_offset = v.off; xfer_len = v.len;
        wdata_in = v.data[0]; byte_en = v.be; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, 32'(a_busy), 32'd1);
        for (int cyc = 0; cyc < 200 && !got_done; cyc++) begin
            @(negedge clk);
            if (!frame && addr_cyc < 0) addr_cyc = cyc;
            if (!devsel) n_dsel++;
            if (!irdy) begin
                n_irdy++;
                if (!trdy) begin
                    n_trdy++;
                    if (n_irdy % 3 != 0) pat_bad++;
                end
            end
            if (a_wack) begin
                nack++;
                if (nack < 4) wdata_in = v.data[nack];
            end
            if (a_rvalid) begin
                if (nrd < 4) check($sformatf("%s_rd%0d", tag, nrd), a_rdata, v.data[nrd]);
                nrd++;
            end
            if (a_done) begin
                got_done = 1'b1; e = a_err; done_cyc = cyc; busy_at_done = a_busy;
            end
        end
        check({tag, "_done"}, 32'(got_done), 32'd1);
        check({tag, "_err"}, 32'(e), 32'(v.err));
        check({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
        check({tag, "_acks"}, 32'(nack), (v.wr && !v.err) ? 32'(v.len) : 32'd0);
        check({tag, "_rvalids"}, 32'(nrd), (!v.wr && !v.err) ? 32'(v.len) : 32'd0);
        @(negedge clk);
        post_frame = frame; post_irdy = irdy;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = mk(1'b1, 2'd2, 4'd3,  4'd4, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 4'hF, 1'b0);
        vecs[1] = mk(1'b0, 2'd2, 4'd3,  4'd4, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 4'hF, 1'b0);
        vecs[2] = mk(1'b1, 2'd2, 4'd15, 4'd2, 32'hAAAA0000, 32'hBBBB0001, 32'h0, 32'h0, 4'hF, 1'b0);
        vecs[3] = mk(1'b0, 2'd2, 4'd15, 4'd2, 32'hAAAA0000, 32'hBBBB0001, 32'h0, 32'h0, 4'hF, 1'b0);
        vecs[4] = mk(1'b1, 2'd2, 4'd8,  4'd1, 32'h00000000, 32'h0, 32'h0, 32'h0, 4'hF, 1'b0);
        vecs[5] = mk(1'b1, 2'd2, 4'd8,  4'd1, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 4'b0101, 1'b0);
        vecs[6] = mk(1'b0, 2'd2, 4'd8,  4'd1, 32'h00AD00EF, 32'h0, 32'h0, 32'h0, 4'hF, 1'b0);

        rst_n = 1'b0; start = 1'b0; xfer_write = 1'b0; xfer_target = 2'd0;
        xfer_offset = 4'd0; xfer_len = 4'd0; wdata_in = 32'd0; byte_en = 4'd0;
        repeat (2) @(negedge clk);
        check("rst_req", 32'(a_req), 32'd1);
        check("rst_outs", 32'({a_busy, a_done, a_err, a_wack, a_rvalid}), 32'd0);
        check("rst_ctrl_released", 32'({frame, irdy, trdy, devsel}), 32'hF);
        check("rst_ad_released", ad, 32'hFFFFFFFF);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) run_txn(vecs[i], $sformatf("v%0d", i));

        // Wait-state target: each word takes WAIT_STATES+1 = 3 data cycles
        run_txn(mk(1'b1, 2'd0, 4'd5, 4'd3, 32'hC0C0C0C0, 32'hC1C1C1C1, 32'hC2C2C2C2, 32'h0, 4'hF, 1'b0), "ws_wr");
        check("ws_data_cycles", 32'(n_irdy), 32'd9);
        check("ws_trdy_cycles", 32'(n_trdy), 32'd3);
        check("ws_trdy_pattern", 32'(pat_bad), 32'd0);
        run_txn(mk(1'b0, 2'd0, 4'd5, 4'd3, 32'hC0C0C0C0, 32'hC1C1C1C1, 32'hC2C2C2C2, 32'h0, 4'hF, 1'b0), "ws_rd");
        check("ws_rd_data_cycles", 32'(n_irdy), 32'd9);

        // Master abort to an unused ID
        run_txn(mk(1'b0, 2'd3, 4'd0, 4'd2, 32'h0, 32'h0, 32'h0, 32'h0, 4'hF, 1'b1), "abort");
        check("abort_no_devsel", 32'(n_dsel), 32'd0);
        check("abort_latency", 32'(done_cyc - addr_cyc), 32'd6);
        check("abort_released", 32'({post_frame, post_irdy}), 32'h3);

        // Reset in the middle of a write burst
        xfer_write = 1'b1; xfer_target = 2'd2; xfer_offset = 4'd10; xfer_len = 4'd4;
        wdata_in = 32'h55555555; byte_en = 4'hF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && irdy; i++) @(negedge clk);
        check("mid_in_data", 32'({irdy, devsel}), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_ctrl_released", 32'({frame, irdy, trdy, devsel}), 32'hF);
        check("mid_ad_released", ad, 32'hFFFFFFFF);
        check("mid_busy", 32'(a_busy), 32'd0);
        check("mid_req", 32'(a_req), 32'd1);
        check("mid_no_done", 32'(a_done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_txn(mk(1'b0, 2'd2, 4'd3, 4'd1, 32'h11111111, 32'h0, 32'h0, 32'h0, 4'hF, 1'b0), "post_rst");

        check("passive_host_quiet",
              32'({b_busy, b_done, b_err, b_wack, b_rvalid, ~b_req, c_busy, c_done, c_err, c_wack, c_rvalid, ~c_req}),
              32'd0);
        check("passive_rdata", b_rdata | c_rdata, 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
